fmps_link_tx: RTL

//  Transmit side of the FMPS link: on each FA strobe, snapshots the local FMPS status word(s)
//  and emits one packet (header + NUM_DATA_WORDS data beats) on the outgoing CCW/CW AXI-Stream

---
 rtl/fmps_pkg.sv | 21 ++
 rtl/fmps_link_tx.sv | 126 ++++++++++++
 2 files changed

// File: rtl/fmps_pkg.sv
// Shared FMPS link definitions: header layout, FSM state encoding and header builder.
// Also imported by the receive side (fmpsReadLinks).
package fmps_pkg;

  localparam logic [15:0] HEADER_MAGIC     = 16'hB6CF;
  localparam int          MAGIC_START_BIT  = 16;
  localparam int          INDEX_START_BIT  = 10;
  localparam int          FMPS_COUNT_WIDTH = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HEADER = 2'd1,
    ST_DATA   = 2'd2
  } fmpsState_t;

  // Caller passes the index zero-extended; bit 15 of the header stays 0 for indices up to 5 bits.
  function automatic logic [31:0] fmpsHeader(input logic [15:0] magic, input logic [31:0] index);
    return (32'(magic) << MAGIC_START_BIT) | (index << INDEX_START_BIT);
  endfunction

endpackage

// File: rtl/fmps_link_tx.sv
// FMPS link transmitter: on each accepted FA strobe sends header + NUM_DATA_WORDS status beats
// on the AXI-Stream link, with back-pressure, start gating and sent/dropped packet counters.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  ST_IDLE   | no packet in flight, TVALID=0, waiting for a gated FA strobe
//  ST_HEADER | presenting the header beat until it is accepted
//  ST_DATA   | presenting status word beatQ; last word carries TLAST
module fmps_link_tx
  import fmps_pkg::*;
#(
  parameter int          INDEX_WIDTH    = FMPS_COUNT_WIDTH,
  parameter int          NUM_DATA_WORDS = 1,
  parameter logic [15:0] HEADER_MAGIC   = fmps_pkg::HEADER_MAGIC
) (
  input  logic                         auClk,
  input  logic                         auResetN,
  input  logic                         auFAstrobe,
  input  logic                         auChannelUp,
  input  logic                         auInhibit,
  input  logic [INDEX_WIDTH-1:0]       fmpsIndex,
  input  logic [32*NUM_DATA_WORDS-1:0] fmpsStatus,
  output logic [31:0]                  auFMPSlinkTDATA,
  output logic                         auFMPSlinkTVALID,
  output logic                         auFMPSlinkTLAST,
  input  logic                         auFMPSlinkTREADY,
  output logic                         busy,
  output logic [15:0]                  pktCount,
  output logic [7:0]                   dropCount
);

  localparam logic [1:0] LAST_BEAT = 2'(NUM_DATA_WORDS - 1);

  fmpsState_t  stateQ, stateD;
  logic [1:0]  beatQ, beatD;
  logic [31:0] headerQ;
  logic [127:0] statusQ;

  logic handshake, startOk, lastHs, loadNew, dropEvent;

  assign handshake = auFMPSlinkTVALID & auFMPSlinkTREADY;
  assign startOk   = auFAstrobe & auChannelUp & ~auInhibit;
  assign lastHs    = (stateQ == ST_DATA) && handshake && (beatQ == LAST_BEAT);
  assign dropEvent = auFAstrobe & ~loadNew;

  always_ff @(posedge auClk) begin
    if (!auResetN) begin
      stateQ <= ST_IDLE;
      beatQ  <= 2'd0;
    end else begin
      stateQ <= stateD;
      beatQ  <= beatD;
    end
  end

  always_comb begin
    stateD  = stateQ;
    beatD   = beatQ;
    loadNew = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        beatD = 2'd0;
        if (startOk) begin
          stateD  = ST_HEADER;
          loadNew = 1'b1;
        end
      end
      ST_HEADER: begin
        if (handshake) begin
          stateD = ST_DATA;
          beatD  = 2'd0;
        end
      end
      ST_DATA: begin
        if (handshake) begin
          if (beatQ == LAST_BEAT) begin
            // A strobe landing on the final handshake chains straight into the next header.
            beatD = 2'd0;
            if (startOk) begin
              stateD  = ST_HEADER;
              loadNew = 1'b1;
            end else begin
              stateD = ST_IDLE;
            end
          end else begin
            beatD = beatQ + 2'd1;
          end
        end
      end
      default: begin
        stateD = ST_IDLE;
        beatD  = 2'd0;
      end
    endcase
  end

  always_comb begin
    auFMPSlinkTVALID = (stateQ != ST_IDLE);
    busy             = (stateQ != ST_IDLE);
    auFMPSlinkTLAST  = (stateQ == ST_DATA) && (beatQ == LAST_BEAT);
    auFMPSlinkTDATA  = 32'd0;
    if (stateQ == ST_HEADER)
      auFMPSlinkTDATA = headerQ;
    else if (stateQ == ST_DATA)
      auFMPSlinkTDATA = statusQ[{beatQ, 5'd0} +: 32];
  end

  always_ff @(posedge auClk) begin
    if (!auResetN) begin
      headerQ   <= 32'd0;
      statusQ   <= 128'd0;
      pktCount  <= 16'd0;
      dropCount <= 8'd0;
    end else begin
      if (loadNew) begin
        headerQ <= fmpsHeader(HEADER_MAGIC, 32'(fmpsIndex));
        statusQ <= 128'(fmpsStatus);
      end
      if (lastHs)
        pktCount <= pktCount + 16'd1;
      if (dropEvent && (dropCount != 8'hFF))
        dropCount <= dropCount + 8'd1;
    end
  end

endmodule
